wb_unit: RTL and testbench

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit_if.sv | 36 +++
 rtl/wb_unit.sv | 133 +++++++++++++
 tb/tb_wb_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/wb_unit_if.sv
// Write-back unit bus: MEM/WB instruction handshake, load response, and
// register-file write / retire outputs.
interface wb_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_reg_write;
    logic [REG_AW-1:0] in_rd;
    logic [1:0]        in_wb_sel;
    logic [2:0]        in_funct3;
    logic [1:0]        in_addr_lo;
    logic [XLEN-1:0]   in_alu_result;
    logic [XLEN-1:0]   in_pc_plus4;
    logic [XLEN-1:0]   in_imm;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [CNT_W-1:0]  retire_count;

    modport master (
        output in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
        input  in_ready, rf_we, rf_waddr, rf_wdata, retire_count
    );

    modport slave (
        input  in_valid, in_reg_write, in_rd, in_wb_sel, in_funct3, in_addr_lo,
               in_alu_result, in_pc_plus4, in_imm, mem_rsp_valid, mem_rsp_data,
        output in_ready, rf_we, rf_waddr, rf_wdata, retire_count
    );
endinterface

// File: rtl/wb_unit.sv
// Write-back stage: selects write data, formats loads, waits for late load
// responses, and issues a registered one-cycle register-file write per retire.
module wb_unit #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        rst,
    wb_unit_if.slave    bus
);
    typedef enum logic {IDLE, WAIT_MEM} state_t;

    localparam logic [1:0] SEL_ALU = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_PC4 = 2'b10;

    state_t            state, state_nxt;
    logic              cap_we;
    logic [REG_AW-1:0] cap_rd;
    logic [2:0]        cap_f3;
    logic [1:0]        cap_alo;

    logic              done;
    logic              done_we;
    logic [REG_AW-1:0] done_rd;
    logic [XLEN-1:0]   done_data;
    logic              capture;
    logic              accept;

    logic              we_q;
    logic [REG_AW-1:0] waddr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [CNT_W-1:0]  cnt_q;

    // Half lane uses only addr_lo[1]; misaligned halves are silently truncated.
    function automatic logic [XLEN-1:0] fmt_load(input logic [XLEN-1:0] d,
                                                 input logic [2:0] f3,
                                                 input logic [1:0] alo);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{alo, 3'b000} +: 8];
        h = alo[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  fmt_load = {{(XLEN-8){b[7]}}, b};
            3'b001:  fmt_load = {{(XLEN-16){h[15]}}, h};
            3'b100:  fmt_load = {{(XLEN-8){1'b0}}, b};
            3'b101:  fmt_load = {{(XLEN-16){1'b0}}, h};
            default: fmt_load = d;
        endcase
    endfunction

    assign bus.in_ready = (state == IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        done_we   = bus.in_reg_write;
        done_rd   = bus.in_rd;
        done_data = bus.in_alu_result;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.in_wb_sel)
                        SEL_ALU: done_data = bus.in_alu_result;
                        SEL_PC4: done_data = bus.in_pc_plus4;
                        SEL_MEM: done_data = fmt_load(bus.mem_rsp_data, bus.in_funct3,
                                                      bus.in_addr_lo);
                        default: done_data = bus.in_imm;
                    endcase
                    if (bus.in_wb_sel != SEL_MEM || bus.mem_rsp_valid) begin
                        done = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = WAIT_MEM;
                    end
                end
            end
            WAIT_MEM: begin
                done_we   = cap_we;
                done_rd   = cap_rd;
                done_data = fmt_load(bus.mem_rsp_data, cap_f3, cap_alo);
                if (bus.mem_rsp_valid) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cap_we  <= 1'b0;
            cap_rd  <= '0;
            cap_f3  <= '0;
            cap_alo <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                cap_we  <= bus.in_reg_write;
                cap_rd  <= bus.in_rd;
                cap_f3  <= bus.in_funct3;
                cap_alo <= bus.in_addr_lo;
            end
        end
    end

    // Address/data follow every retire, even ones suppressed by rd=0 or no reg_write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            we_q <= done && done_we && (done_rd != '0);
            if (done) begin
                waddr_q <= done_rd;
                wdata_q <= done_data;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.rf_we        = we_q;
    assign bus.rf_waddr     = waddr_q;
    assign bus.rf_wdata     = wdata_q;
    assign bus.retire_count = cnt_q;
endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: default instance plus a 4-bit retire counter
// instance for wrap behaviour.
module tb_wb_unit;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    wb_unit_if #(.XLEN(32), .REG_AW(5), .CNT_W(32)) bus_a ();
    wb_unit_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  bus_b ();

    wb_unit #(.XLEN(32), .REG_AW(5), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    wb_unit #(.XLEN(32), .REG_AW(5), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        bus_a.in_valid      = 1'b0;
        bus_a.in_reg_write  = 1'b0;
        bus_a.in_rd         = '0;
        bus_a.in_wb_sel     = 2'b00;
        bus_a.in_funct3     = 3'b000;
        bus_a.in_addr_lo    = 2'b00;
        bus_a.in_alu_result = '0;
        bus_a.in_pc_plus4   = '0;
        bus_a.in_imm        = '0;
        bus_a.mem_rsp_valid = 1'b0;
        bus_a.mem_rsp_data  = '0;
    endtask

    task automatic op_a(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                        input logic [31:0] val);
        idle_a();
        bus_a.in_valid      = 1'b1;
        bus_a.in_reg_write  = we;
        bus_a.in_rd         = rd;
        bus_a.in_wb_sel     = sel;
        bus_a.in_alu_result = (sel == 2'b00) ? val : 32'h0BAD_0000;
        bus_a.in_pc_plus4   = (sel == 2'b10) ? val : 32'h0BAD_0001;
        bus_a.in_imm        = (sel == 2'b11) ? val : 32'h0BAD_0002;
    endtask

    // Load whose response arrives in the accepting cycle.
    task automatic load_now(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [1:0] alo, input logic [31:0] d,
                            input logic [31:0] exp, input int cnt);
        idle_a();
        bus_a.in_valid      = 1'b1;
        bus_a.in_reg_write  = 1'b1;
        bus_a.in_rd         = rd;
        bus_a.in_wb_sel     = 2'b01;
        bus_a.in_funct3     = f3;
        bus_a.in_addr_lo    = alo;
        bus_a.mem_rsp_valid = 1'b1;
        bus_a.mem_rsp_data  = d;
        step();
        idle_a();
        chk({tag, "_we"}, 32'(bus_a.rf_we), 32'd1);
        chk({tag, "_waddr"}, 32'(bus_a.rf_waddr), 32'(rd));
        chk({tag, "_wdata"}, bus_a.rf_wdata, exp);
        chk({tag, "_cnt"}, bus_a.retire_count, 32'(cnt));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_a();
        bus_b.in_valid      = 1'b0;
        bus_b.in_reg_write  = 1'b0;
        bus_b.in_rd         = '0;
        bus_b.in_wb_sel     = 2'b11;
        bus_b.in_funct3     = 3'b000;
        bus_b.in_addr_lo    = 2'b00;
        bus_b.in_alu_result = '0;
        bus_b.in_pc_plus4   = '0;
        bus_b.in_imm        = '0;
        bus_b.mem_rsp_valid = 1'b0;
        bus_b.mem_rsp_data  = '0;

        step();
        step();
        chk("rst_ready", 32'(bus_a.in_ready), 32'd0);
        chk("rst_we", 32'(bus_a.rf_we), 32'd0);
        chk("rst_waddr", 32'(bus_a.rf_waddr), 32'd0);
        chk("rst_wdata", bus_a.rf_wdata, 32'd0);
        chk("rst_cnt", bus_a.retire_count, 32'd0);
        chk("rst_cnt_b", 32'(bus_b.retire_count), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 32'(bus_a.in_ready), 32'd1);

        // ALU op, first edge after release
        op_a(5'd5, 1'b1, 2'b00, 32'h1234_5678);
        step();
        idle_a();
        chk("alu_we", 32'(bus_a.rf_we), 32'd1);
        chk("alu_waddr", 32'(bus_a.rf_waddr), 32'd5);
        chk("alu_wdata", bus_a.rf_wdata, 32'h1234_5678);
        chk("alu_cnt", bus_a.retire_count, 32'd1);
        step();
        chk("alu_pulse", 32'(bus_a.rf_we), 32'd0);
        chk("alu_hold", bus_a.rf_wdata, 32'h1234_5678);

        // Same-cycle loads: sizes, signs, lanes
        load_now("lb3",  5'd1, 3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, 2);
        load_now("lbu3", 5'd2, 3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080, 3);
        load_now("lhu2", 5'd3, 3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF, 4);
        load_now("lh3",  5'd4, 3'b001, 2'd3, 32'h80FF_0000, 32'hFFFF_80FF, 5);
        load_now("lb1",  5'd6, 3'b000, 2'd1, 32'h0000_7F00, 32'h0000_007F, 6);
        load_now("lw",   5'd8, 3'b010, 2'd0, 32'hCAFE_F00D, 32'hCAFE_F00D, 7);
        load_now("f3_3", 5'd9, 3'b011, 2'd1, 32'h80FF_0000, 32'h80FF_0000, 8);

        // Late load: response three cycles after acceptance
        idle_a();
        bus_a.in_valid     = 1'b1;
        bus_a.in_reg_write = 1'b1;
        bus_a.in_rd        = 5'd7;
        bus_a.in_wb_sel    = 2'b01;
        bus_a.in_funct3    = 3'b010;
        step();
        idle_a();
        chk("lw_wait_rdy1", 32'(bus_a.in_ready), 32'd0);
        chk("lw_wait_we", 32'(bus_a.rf_we), 32'd0);
        step();
        chk("lw_wait_rdy2", 32'(bus_a.in_ready), 32'd0);
        step();
        chk("lw_wait_rdy3", 32'(bus_a.in_ready), 32'd0);
        bus_a.mem_rsp_valid = 1'b1;
        bus_a.mem_rsp_data  = 32'hDEAD_BEEF;
        step();
        idle_a();
        chk("lw_late_we", 32'(bus_a.rf_we), 32'd1);
        chk("lw_late_waddr", 32'(bus_a.rf_waddr), 32'd7);
        chk("lw_late_wdata", bus_a.rf_wdata, 32'hDEAD_BEEF);
        chk("lw_late_rdy", 32'(bus_a.in_ready), 32'd1);
        chk("lw_late_cnt", bus_a.retire_count, 32'd9);
        step();
        chk("lw_late_pulse", 32'(bus_a.rf_we), 32'd0);

        // Stray response while idle is ignored
        bus_a.mem_rsp_valid = 1'b1;
        bus_a.mem_rsp_data  = 32'h1111_1111;
        step();
        idle_a();
        chk("stray_we", 32'(bus_a.rf_we), 32'd0);
        chk("stray_wdata", bus_a.rf_wdata, 32'hDEAD_BEEF);
        chk("stray_cnt", bus_a.retire_count, 32'd9);

        // rd=0 and reg_write=0 still retire and update addr/data
        op_a(5'd0, 1'b1, 2'b10, 32'h0000_0104);
        step();
        idle_a();
        chk("x0_we", 32'(bus_a.rf_we), 32'd0);
        chk("x0_wdata", bus_a.rf_wdata, 32'h0000_0104);
        chk("x0_cnt", bus_a.retire_count, 32'd10);
        op_a(5'd3, 1'b0, 2'b11, 32'h0000_0ABC);
        step();
        idle_a();
        chk("nowr_we", 32'(bus_a.rf_we), 32'd0);
        chk("nowr_waddr", 32'(bus_a.rf_waddr), 32'd3);
        chk("nowr_wdata", bus_a.rf_wdata, 32'h0000_0ABC);
        chk("nowr_cnt", bus_a.retire_count, 32'd11);

        // Reset while a load is pending
        idle_a();
        bus_a.in_valid     = 1'b1;
        bus_a.in_reg_write = 1'b1;
        bus_a.in_rd        = 5'd9;
        bus_a.in_wb_sel    = 2'b01;
        step();
        idle_a();
        chk("pend_rdy", 32'(bus_a.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("pend_rst_cnt", bus_a.retire_count, 32'd0);
        step();
        rst = 1'b0;
        bus_a.mem_rsp_valid = 1'b1;
        bus_a.mem_rsp_data  = 32'h5555_5555;
        #1;
        chk("pend_rel_rdy", 32'(bus_a.in_ready), 32'd1);
        step();
        idle_a();
        chk("pend_drop_we", 32'(bus_a.rf_we), 32'd0);
        chk("pend_drop_wdata", bus_a.rf_wdata, 32'd0);
        chk("pend_drop_cnt", bus_a.retire_count, 32'd0);

        op_a(5'd4, 1'b1, 2'b00, 32'h0000_0042);
        step();
        idle_a();
        chk("post_rst_we", 32'(bus_a.rf_we), 32'd1);
        chk("post_rst_wdata", bus_a.rf_wdata, 32'h0000_0042);
        chk("post_rst_cnt", bus_a.retire_count, 32'd1);

        // 17 back-to-back IMM ops on the 4-bit counter instance
        bus_b.in_valid     = 1'b1;
        bus_b.in_reg_write = 1'b1;
        bus_b.in_rd        = 5'd10;
        bus_b.in_wb_sel    = 2'b11;
        for (int i = 0; i < 17; i++) begin
            bus_b.in_imm = 32'h100 + 32'(i);
            step();
            chk("b2b_we", 32'(bus_b.rf_we), 32'd1);
            chk("b2b_wdata", bus_b.rf_wdata, 32'h100 + 32'(i));
        end
        bus_b.in_valid = 1'b0;
        step();
        chk("b2b_end_we", 32'(bus_b.rf_we), 32'd0);
        chk("b2b_wrap_cnt", 32'(bus_b.retire_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
